// File: rtl/regfile_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_ctrl
//   Command sequencer for an external 8 x 32 register file. A command
//   (op, addr_a, addr_b, data_in) is latched when start is seen in IDLE. It is
//   executed over k EXEC cycles, which drive the register-file read/write
//   strobes, and then reported with a one-cycle done pulse.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, op             command request (IDLE only) and command code
//   addr_a, addr_b        register addresses a / b
//   data_in               write / fill data
//   busy, done, err       EXEC flag, completion pulse, illegal-op pulse
//   data_out              registered result of READ / SWAP
//   rf_wAddr/rf_wData/rf_we   register-file write port
//   rf_rAddr/rf_re/rf_rData   register-file read port (rf_rData combinational)
// -----------------------------------------------------------------------------
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [2:0]  addr_a,
  input  logic [2:0]  addr_b,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out,
  output logic [2:0]  rf_wAddr,
  output logic [2:0]  rf_rAddr,
  output logic [31:0] rf_wData,
  output logic        rf_we,
  output logic        rf_re,
  input  logic [31:0] rf_rData
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_READ  = 3'b001,
    OP_WRITE = 3'b010,
    OP_COPY  = 3'b011,
    OP_SWAP  = 3'b100,
    OP_CLEAR = 3'b101,
    OP_FILL  = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [2:0]  a_q, a_d;
  logic [2:0]  b_q, b_d;
  logic [31:0] din_q, din_d;
  logic [2:0]  cnt_q, cnt_d;     // SWAP phase or CLEAR/FILL write address
  logic [31:0] temp_q, temp_d;   // original R[a] held across a SWAP
  logic [31:0] dout_q, dout_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      temp_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    temp_d   = temp_q;
    dout_d   = dout_q;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    rf_we    = 1'b0;
    rf_re    = 1'b0;
    rf_wAddr = '0;
    rf_rAddr = '0;
    rf_wData = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op_e'(op);
          a_d   = addr_a;
          b_d   = addr_b;
          din_d = data_in;
          cnt_d = '0;
          // Zero-length commands skip EXEC entirely.
          if (op_e'(op) == OP_NOP || op_e'(op) == OP_ILL) state_d = DONE;
          else                                            state_d = EXEC;
        end
      end

      EXEC: begin
        busy = 1'b1;
        unique case (op_q)
          OP_READ: begin
            rf_re    = 1'b1;
            rf_rAddr = a_q;
            dout_d   = rf_rData;
            state_d  = DONE;
          end
          OP_WRITE: begin
            rf_we    = 1'b1;
            rf_wAddr = a_q;
            rf_wData = din_q;
            state_d  = DONE;
          end
          OP_COPY: begin
            rf_re    = 1'b1;
            rf_rAddr = a_q;
            rf_we    = 1'b1;
            rf_wAddr = b_q;
            rf_wData = rf_rData;
            state_d  = DONE;
          end
          OP_SWAP: begin
            unique case (cnt_q)
              3'd0: begin
                rf_re    = 1'b1;
                rf_rAddr = a_q;
                temp_d   = rf_rData;
                dout_d   = rf_rData;
                cnt_d    = 3'd1;
              end
              3'd1: begin
                rf_re    = 1'b1;
                rf_rAddr = b_q;
                rf_we    = 1'b1;
                rf_wAddr = a_q;
                rf_wData = rf_rData;
                cnt_d    = 3'd2;
              end
              default: begin
                rf_we    = 1'b1;
                rf_wAddr = b_q;
                rf_wData = temp_q;
                cnt_d    = '0;
                state_d  = DONE;
              end
            endcase
          end
          OP_CLEAR, OP_FILL: begin
            rf_we    = 1'b1;
            rf_wAddr = cnt_q;
            rf_wData = (op_q == OP_FILL) ? din_q : '0;
            // Counter wraps 7 -> 0 on the final write, leaving it ready.
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = DONE;
          end
          default: state_d = DONE;
        endcase
      end

      DONE: begin
        done    = 1'b1;
        err     = (op_q == OP_ILL);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
module tb_regfile_ctrl;

  localparam logic [2:0] NOP = 3'b000, RD = 3'b001, WR = 3'b010, CP = 3'b011,
                         SW = 3'b100, CL = 3'b101, FL = 3'b110, IL = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op, addr_a, addr_b;
  logic [31:0] data_in;
  logic        busy, done, err;
  logic [31:0] data_out;
  logic [2:0]  rf_wAddr, rf_rAddr;
  logic [31:0] rf_wData, rf_rData;
  logic        rf_we, rf_re;

  regfile_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .data_in(data_in),
    .busy(busy), .done(done), .err(err), .data_out(data_out),
    .rf_wAddr(rf_wAddr), .rf_rAddr(rf_rAddr), .rf_wData(rf_wData),
    .rf_we(rf_we), .rf_re(rf_re), .rf_rData(rf_rData)
  );

  always #5 clk = ~clk;

  // Environment register file written by the DUT.
  logic [31:0] mem [8];
  always @(posedge clk) if (rf_we) mem[rf_wAddr] <= rf_wData;
  assign rf_rData = rf_re ? mem[rf_rAddr] : 32'h0;

  // Reference model state.
  logic [31:0] ref_mem [8];
  logic [31:0] ref_dout;

  typedef struct { logic [2:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_wr [$];

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [31:0] din;
    int          k;     // expected EXEC cycles
    logic        e;     // expected err with done
  } vec_t;
  vec_t vecs [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " rf_we"},    32'(rf_we),    32'h0);
    chk({tag, " rf_re"},    32'(rf_re),    32'h0);
    chk({tag, " rf_wAddr"}, 32'(rf_wAddr), 32'h0);
    chk({tag, " rf_rAddr"}, 32'(rf_rAddr), 32'h0);
    chk({tag, " rf_wData"}, rf_wData,      32'h0);
  endtask

  // Scoreboard: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected (t=%0t)",
                 rf_wAddr, rf_wData, $time);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("write_addr", 32'(rf_wAddr), 32'(w.addr));
        chk("write_data", rf_wData, w.data);
      end
    end
  end

  function automatic void add(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                              input logic [31:0] d, input int k, input logic e);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.din = d; v.k = k; v.e = e;
    vecs.push_back(v);
  endfunction

  function automatic void model(input vec_t v);
    logic [31:0] ta, tb;
    wr_t w;
    ta = ref_mem[v.a];
    tb = ref_mem[v.b];
    case (v.op)
      RD: ref_dout = ta;
      WR: begin w.addr = v.a; w.data = v.din; exp_wr.push_back(w); ref_mem[v.a] = v.din; end
      CP: begin w.addr = v.b; w.data = ta; exp_wr.push_back(w); ref_mem[v.b] = ta; end
      SW: begin
        w.addr = v.a; w.data = tb; exp_wr.push_back(w);
        w.addr = v.b; w.data = ta; exp_wr.push_back(w);
        ref_mem[v.a] = tb;
        ref_mem[v.b] = ta;
        ref_dout = ta;
      end
      CL, FL: begin
        for (int i = 0; i < 8; i++) begin
          w.addr = 3'(i);
          w.data = (v.op == FL) ? v.din : 32'h0;
          exp_wr.push_back(w);
          ref_mem[i] = w.data;
        end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first IDLE cycle.
  // inject_at > 0 raises start (with a WRITE) during that cycle for one cycle.
  task automatic run_cmd(input vec_t v, input int inject_at);
    model(v);
    start = 1'b1; op = v.op; addr_a = v.a; addr_b = v.b; data_in = v.din;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= v.k + 2; i++) begin
      @(negedge clk);
      chk($sformatf("op%0d busy c%0d", v.op, i), 32'(busy), 32'(i <= v.k));
      chk($sformatf("op%0d done c%0d", v.op, i), 32'(done), 32'(i == v.k + 1));
      chk($sformatf("op%0d err c%0d", v.op, i),  32'(err),  32'((i == v.k + 1) && v.e));
      if (i > v.k) chk_quiet($sformatf("op%0d c%0d", v.op, i));
      if (i == inject_at) begin
        start = 1'b1; op = WR; addr_a = 3'd0; data_in = 32'hBAD0BAD0;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
    end
    chk($sformatf("op%0d data_out", v.op), data_out, ref_dout);
    chk($sformatf("op%0d writes_left", v.op), 32'(exp_wr.size()), 32'h0);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 8; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    ref_dout = 32'h0;
    reset_n = 1'b0; start = 1'b0; op = NOP; addr_a = '0; addr_b = '0; data_in = '0;

    #1;
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset err",  32'(err),  32'h0);
    chk("reset data_out", data_out, 32'h0);
    chk_quiet("reset");

    add(WR, 3'd3, 3'd0, 32'hDEADBEEF, 1, 1'b0);
    add(RD, 3'd3, 3'd0, 32'h0,        1, 1'b0);
    add(WR, 3'd1, 3'd0, 32'h00000011, 1, 1'b0);
    add(WR, 3'd6, 3'd0, 32'h00000066, 1, 1'b0);
    add(SW, 3'd1, 3'd6, 32'h0,        3, 1'b0);
    add(RD, 3'd1, 3'd0, 32'h0,        1, 1'b0);
    add(RD, 3'd6, 3'd0, 32'h0,        1, 1'b0);
    add(CP, 3'd3, 3'd5, 32'h0,        1, 1'b0);
    add(RD, 3'd5, 3'd0, 32'h0,        1, 1'b0);
    add(WR, 3'd2, 3'd0, 32'h12345678, 1, 1'b0);
    add(CP, 3'd2, 3'd2, 32'h0,        1, 1'b0);
    add(SW, 3'd6, 3'd6, 32'h0,        3, 1'b0);
    add(RD, 3'd2, 3'd0, 32'h0,        1, 1'b0);
    add(NOP, 3'd4, 3'd5, 32'hFFFFFFFF, 0, 1'b0);
    add(IL, 3'd1, 3'd2, 32'hFFFFFFFF, 0, 1'b1);
    add(FL, 3'd0, 3'd0, 32'hA5A5A5A5, 8, 1'b0);
    add(RD, 3'd0, 3'd0, 32'h0,        1, 1'b0);
    add(RD, 3'd7, 3'd0, 32'h0,        1, 1'b0);
    add(CL, 3'd0, 3'd0, 32'hFFFFFFFF, 8, 1'b0);
    for (int i = 0; i < 8; i++) add(RD, 3'(i), 3'd0, 32'h0, 1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    foreach (vecs[i]) run_cmd(vecs[i], 0);

    // start raised during SWAP EXEC must be ignored.
    v.op = WR; v.a = 3'd2; v.b = 3'd0; v.din = 32'h22222222; v.k = 1; v.e = 1'b0;
    run_cmd(v, 0);
    v.op = WR; v.a = 3'd4; v.din = 32'h44444444;
    run_cmd(v, 0);
    v.op = SW; v.a = 3'd2; v.b = 3'd4; v.k = 3;
    run_cmd(v, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_inject busy", 32'(busy), 32'h0);
      chk("post_inject done", 32'(done), 32'h0);
    end
    v.op = RD; v.a = 3'd0; v.k = 1;
    run_cmd(v, 0);
    v.a = 3'd2;
    run_cmd(v, 0);

    // Reset during CLEAR after four writes.
    v.op = FL; v.din = 32'h5A5A5A5A; v.k = 8;
    run_cmd(v, 0);
    for (int i = 0; i < 4; i++) begin
      wr_t w;
      w.addr = 3'(i); w.data = 32'h0;
      exp_wr.push_back(w);
      ref_mem[i] = 32'h0;
    end
    start = 1'b1; op = CL; addr_a = '0; addr_b = '0; data_in = '0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("clear busy", 32'(busy), 32'h1);
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    chk("abort err",  32'(err),  32'h0);
    chk("abort data_out", data_out, 32'h0);
    chk_quiet("abort");
    chk("abort writes_left", 32'(exp_wr.size()), 32'h0);
    ref_dout = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk_quiet("in_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v.op = RD; v.a = 3'(i); v.k = 1;
      run_cmd(v, 0);
      chk($sformatf("after_abort R%0d", i), data_out,
          (i < 4) ? 32'h0 : 32'h5A5A5A5A);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, with clk and reset_n listed first in the port order.
REQ-002 The ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command request; sampled only in IDLE.
- op  in  3  command code (REQ-006).
- addr_a  in  3  first register address.
- addr_b  in  3  second register address.
- data_in  in  32  write/fill data.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-op pulse, coincident with done.
- data_out  out  32  registered read result.
- rf_wAddr  out  3  register-file write address.
- rf_rAddr  out  3  register-file read address.
- rf_wData  out  32  register-file write data.
- rf_we  out  1  register-file write enable.
- rf_re  out  1  register-file read enable.
- rf_rData  in  32  register-file read data; combinational from rf_rAddr/rf_re.
REQ-003 The block SHALL have no parameters, because the file size is fixed at 8 x 32.

Function
REQ-004 The FSM SHALL have the states IDLE, EXEC and DONE.
- busy SHALL be high in EXEC only.
- done SHALL be high in DONE only.
- DONE SHALL always return to IDLE on the next edge.
REQ-005 On the edge where IDLE sees start=1:
- op, addr_a, addr_b and data_in SHALL be latched.
- The FSM SHALL move to EXEC, or to DONE directly for NOP and illegal op.
- start SHALL be ignored in EXEC and DONE.
REQ-006 The commands SHALL be as follows, with k = number of EXEC cycles:
- 000 NOP: k=0.
- 001 READ: k=1; data_out <= R[a].
- 010 WRITE: k=1; R[a] <= data_in.
- 011 COPY: k=1; R[b] <= R[a].
- 100 SWAP: k=3; exchange R[a] and R[b].
- 101 CLEAR: k=8; R[0..7] <= 0.
- 110 FILL: k=8; R[0..7] <= data_in.
- 111 illegal: k=0; err=1.
REQ-007 done SHALL go high exactly k+1 cycles after the start-sampling edge.
REQ-008 READ SHALL drive rf_re=1 and rf_rAddr=a, and SHALL capture rf_rData into data_out at the end of the EXEC cycle.
REQ-009 COPY SHALL, in one cycle, drive:
- rf_re=1 and rf_rAddr=a;
- rf_we=1, rf_wAddr=b and rf_wData=rf_rData.
REQ-010 SWAP SHALL use an internal 32-bit temp register over three cycles:
- Cycle 1: read a into temp; rf_we=0.
- Cycle 2: read b and write it to a (rf_wData=rf_rData).
- Cycle 3: write temp to b; rf_re=0.
- SWAP SHALL also load the original R[a] into data_out.
REQ-011 CLEAR and FILL SHALL use a 3-bit counter starting at 0 and driving rf_wAddr.
- Each cycle SHALL write one register, in order 0..7.
- The counter SHALL wrap to 0 after writing 7, and EXEC SHALL then exit.
REQ-012 When addr_a==addr_b, COPY and SWAP SHALL execute normally and leave the register contents unchanged.
REQ-013 Outside active read/write cycles, rf_we and rf_re SHALL be 0, and rf_wAddr, rf_rAddr and rf_wData SHALL be 0.
REQ-014 rf_we SHALL never be asserted in IDLE, in DONE, or for NOP or illegal op.
REQ-015 data_out SHALL change only at the READ or SWAP capture points.

Reset
REQ-016 Asserting reset_n=0 SHALL immediately force:
- state IDLE;
- busy=0, done=0 and err=0;
- data_out=0 and temp=0;
- counter=0;
- all rf_* outputs = 0.
REQ-017 Reset asserted mid-command SHALL abort the command.
- No further rf_we pulses SHALL occur.
- Registers already written SHALL keep their values (the register file is not reset by this block).
REQ-018 After reset_n rises, the first start SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- WRITE a=3, data 0xDEADBEEF, then READ a=3 -> done 2 cycles after each start; data_out=0xDEADBEEF.
- R1=0x11, R6=0x66; SWAP a=1 b=6 -> busy for 3 cycles, done at cycle 4; R1=0x66, R6=0x11; data_out=0x11.
- FILL data 0xA5A5A5A5 then CLEAR -> 8 writes each, addresses 0..7 in order; all registers read back 0; done at cycle 9.
- op=111 -> done and err together for one cycle at cycle 1; rf_we stays 0.
- start pulsed during a SWAP EXEC -> ignored; no extra command runs.
- reset_n pulled low during CLEAR after 4 writes -> outputs go 0 immediately; R0..R3 = 0, R4..R7 unchanged.
